// File: rtl/inst_sram_axi_rd_bridge_pkg.sv
// Shared AXI3 read-channel constants and types for the instruction fetch bridge.
// Widths and encodings match the core-side SRAM-like fetch interface.
package inst_sram_axi_rd_bridge_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int ID_W   = 4;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;

    localparam logic [2:0] SIZE_BYTE = 3'b000;
    localparam logic [2:0] SIZE_HALF = 3'b001;
    localparam logic [2:0] SIZE_WORD = 3'b010;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {
        AR_IDLE = 1'b0,
        AR_BUSY = 1'b1
    } ar_state_t;

    // Counter must hold every value 0..n inclusive.
    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/inst_sram_axi_rd_bridge.sv
// Instruction-fetch SRAM-like to AXI3 single-beat read bridge, in-order, single ID.
// Optional R-channel protocol checker enabled by INST_RD_BRIDGE_CHK_EN.
module inst_sram_axi_rd_bridge
    import inst_sram_axi_rd_bridge_pkg::*;
#(
    parameter int         OUTSTANDING = 2,
    parameter logic [3:0] ARID_VAL    = 4'd0
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              inst_sram_req,
    input  logic              inst_sram_wr,
    input  logic [1:0]        inst_sram_size,
    input  logic [3:0]        inst_sram_wstrb,
    input  logic [ADDR_W-1:0] inst_sram_addr,
    input  logic [DATA_W-1:0] inst_sram_wdata,
    output logic              inst_sram_addr_ok,
    output logic              inst_sram_data_ok,
    output logic [DATA_W-1:0] inst_sram_rdata,

    output logic [ID_W-1:0]   arid,
    output logic [ADDR_W-1:0] araddr,
    output logic [7:0]        arlen,
    output logic [2:0]        arsize,
    output logic [1:0]        arburst,
    output logic [1:0]        arlock,
    output logic [3:0]        arcache,
    output logic [2:0]        arprot,
    output logic              arvalid,
    input  logic              arready,

    input  logic [ID_W-1:0]   rid,
    input  logic [DATA_W-1:0] rdata,
    input  logic [1:0]        rresp,
    input  logic              rlast,
    input  logic              rvalid,
    output logic              rready,

    output logic              rd_err
);

    localparam int CW = cnt_width(OUTSTANDING);
    localparam logic [CW-1:0] CNT_MAX = CW'(OUTSTANDING);

    ar_state_t         state;
    ar_state_t         state_nxt;
    logic [CW-1:0]     cnt;
    logic              addr_ok;
    logic              beat;
    logic              rready_q;
    logic              data_ok_q;
    logic [DATA_W-1:0] rdata_q;

    assign arid    = ARID_VAL;
    assign arlen   = 8'd0;
    assign arburst = BURST_INCR;
    assign arlock  = 2'b00;
    assign arcache = 4'b0000;
    assign arprot  = 3'b000;

    assign arvalid           = (state == AR_BUSY);
    assign rready            = rready_q;
    assign inst_sram_addr_ok = addr_ok;
    assign inst_sram_data_ok = data_ok_q;
    assign inst_sram_rdata   = rdata_q;

    assign beat = rvalid & rready_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= AR_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Only one AR may be pending, so acceptance requires the FSM to be idle.
    always_comb begin
        state_nxt = state;
        addr_ok   = 1'b0;
        unique case (state)
            AR_IDLE: begin
                addr_ok = inst_sram_req & ~inst_sram_wr & (cnt < CNT_MAX);
                if (addr_ok) begin
                    state_nxt = AR_BUSY;
                end
            end
            AR_BUSY: begin
                if (arready) begin
                    state_nxt = AR_IDLE;
                end
            end
            default: state_nxt = AR_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            araddr    <= '0;
            arsize    <= 3'b000;
            rready_q  <= 1'b0;
            data_ok_q <= 1'b0;
            rdata_q   <= '0;
            cnt       <= '0;
        end else begin
            rready_q  <= 1'b1;
            data_ok_q <= beat;
            if (addr_ok) begin
                araddr <= inst_sram_addr;
                arsize <= {1'b0, inst_sram_size};
            end
            if (beat) begin
                rdata_q <= rdata;
            end
            // A fetch stays counted until its data_ok pulse has been shown.
            unique case ({addr_ok, data_ok_q})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

`ifdef INST_RD_BRIDGE_CHK_EN
    logic err_q;
    logic bad_beat;

    assign bad_beat = (rresp != RESP_OKAY)
                    | (rid != ARID_VAL)
                    | ~rlast
                    | (cnt == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            err_q <= 1'b0;
        end else if (beat & bad_beat) begin
            err_q <= 1'b1;
        end
    end

    assign rd_err = err_q;
`else
    assign rd_err = 1'b0;
`endif

    logic unused_inputs;
    assign unused_inputs = ^{inst_sram_wstrb, inst_sram_wdata,
                             rid, rresp, rlast};

endmodule

// File: tb/tb_inst_sram_axi_rd_bridge.sv
// Directed bench for the instruction fetch AXI read bridge.
// Table of per-cycle vectors plus hand-written multi-cycle sequences.
module tb_inst_sram_axi_rd_bridge;

`ifdef INST_RD_BRIDGE_CHK_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        req, wr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] addr, wdata;
    logic        addr_ok, data_ok;
    logic [31:0] inst_rdata;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst, arlock;
    logic [3:0]  arcache;
    logic [2:0]  arprot;
    logic        arvalid, arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast, rvalid, rready;
    logic        rd_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    inst_sram_axi_rd_bridge #(.OUTSTANDING(2), .ARID_VAL(4'd0)) dut (
        .clk(clk), .reset(reset),
        .inst_sram_req(req), .inst_sram_wr(wr), .inst_sram_size(size),
        .inst_sram_wstrb(wstrb), .inst_sram_addr(addr),
        .inst_sram_wdata(wdata), .inst_sram_addr_ok(addr_ok),
        .inst_sram_data_ok(data_ok), .inst_sram_rdata(inst_rdata),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
        .arburst(arburst), .arlock(arlock), .arcache(arcache),
        .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
        .rvalid(rvalid), .rready(rready), .rd_err(rd_err)
    );

    typedef struct {
        logic        req, wr;
        logic [31:0] addr;
        logic        arready, rvalid;
        logic [31:0] rdat;
        logic        e_aok, e_arv;
        logic [31:0] e_araddr;
        logic        e_dok;
        logic [31:0] e_rdata;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(logic rq, logic w, logic [31:0] a,
                                logic ar, logic rv, logic [31:0] rd,
                                logic eaok, logic earv, logic [31:0] eaa,
                                logic edok, logic [31:0] erd);
        vec_t v;
        v.req = rq; v.wr = w; v.addr = a; v.arready = ar;
        v.rvalid = rv; v.rdat = rd; v.e_aok = eaok; v.e_arv = earv;
        v.e_araddr = eaa; v.e_dok = edok; v.e_rdata = erd;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    int n_acc;
    int n_dok;

    initial begin
        reset = 1'b1; req = 1'b0; wr = 1'b0; size = 2'b10;
        wstrb = 4'h0; addr = '0; wdata = '0; arready = 1'b0;
        rid = 4'd0; rdata = '0; rresp = 2'b00; rlast = 1'b1; rvalid = 1'b0;

        // reset state
        tick(); tick(); settle();
        chk("rst_arvalid", 32'(arvalid), 32'd0);
        chk("rst_araddr", araddr, 32'd0);
        chk("rst_arsize", 32'(arsize), 32'd0);
        chk("rst_rready", 32'(rready), 32'd0);
        chk("rst_data_ok", 32'(data_ok), 32'd0);
        chk("rst_rdata", inst_rdata, 32'd0);
        chk("rst_rd_err", 32'(rd_err), 32'd0);
        chk("const_arburst", 32'(arburst), 32'd1);
        tick();
        reset = 1'b0;
        tick(); settle();
        chk("rready_up", 32'(rready), 32'd1);
        tick();

        // basic fetch, wr=1 rejection, and a stalled-AR fetch
        vq.push_back(mk(1,0,32'h1c000000,1,0,0,         1,0,0,          0,0));
        vq.push_back(mk(0,0,0,           1,0,0,         0,1,32'h1c000000,0,0));
        vq.push_back(mk(0,0,0,           0,1,32'h02800c0c,0,0,0,        0,0));
        vq.push_back(mk(0,0,0,           0,0,0,         0,0,0,          1,32'h02800c0c));
        vq.push_back(mk(0,0,0,           0,0,0,         0,0,0,          0,0));
        for (int i = 0; i < 10; i++)
            vq.push_back(mk(1,1,32'h1c000040,1,0,0,     0,0,0,          0,0));
        vq.push_back(mk(1,0,32'h1c000004,0,0,0,         1,0,0,          0,0));
        vq.push_back(mk(0,0,0,           0,0,0,         0,1,32'h1c000004,0,0));
        vq.push_back(mk(0,0,0,           1,0,0,         0,1,32'h1c000004,0,0));
        vq.push_back(mk(0,0,0,           0,1,32'hdeadbeef,0,0,0,        0,0));
        vq.push_back(mk(0,0,0,           0,0,0,         0,0,0,          1,32'hdeadbeef));
        vq.push_back(mk(0,0,0,           0,0,0,         0,0,0,          0,0));

        foreach (vq[i]) begin
            req = vq[i].req; wr = vq[i].wr; addr = vq[i].addr;
            arready = vq[i].arready; rvalid = vq[i].rvalid;
            rdata = vq[i].rdat;
            settle();
            chk($sformatf("v%0d_addr_ok", i), 32'(addr_ok), 32'(vq[i].e_aok));
            chk($sformatf("v%0d_arvalid", i), 32'(arvalid), 32'(vq[i].e_arv));
            chk($sformatf("v%0d_data_ok", i), 32'(data_ok), 32'(vq[i].e_dok));
            if (vq[i].e_arv) begin
                chk($sformatf("v%0d_araddr", i), araddr, vq[i].e_araddr);
                chk($sformatf("v%0d_arsize", i), 32'(arsize), 32'h2);
                chk($sformatf("v%0d_arlen", i), 32'(arlen), 32'h0);
            end
            if (vq[i].e_dok)
                chk($sformatf("v%0d_rdata", i), inst_rdata, vq[i].e_rdata);
            tick();
        end
        req = 0; wr = 0; arready = 0; rvalid = 0;

        // AR held off by arready: payload stable, no second accept
        req = 1; addr = 32'h1c000100; settle();
        chk("s2_accA", 32'(addr_ok), 32'd1);
        tick();
        addr = 32'h1c000200;
        for (int i = 0; i < 6; i++) begin
            arready = (i == 5);
            settle();
            chk($sformatf("s2_arv%0d", i), 32'(arvalid), 32'd1);
            chk($sformatf("s2_araddr%0d", i), araddr, 32'h1c000100);
            chk($sformatf("s2_noacc%0d", i), 32'(addr_ok), 32'd0);
            tick();
        end
        arready = 0; settle();
        chk("s2_arv_drop", 32'(arvalid), 32'd0);
        chk("s2_accB", 32'(addr_ok), 32'd1);
        tick();
        req = 0; arready = 1; settle();
        chk("s2_araddrB", araddr, 32'h1c000200);
        tick();
        arready = 0; rvalid = 1; rdata = 32'h11111111; tick();
        rdata = 32'h22222222; settle();
        chk("s2_dokA", 32'(data_ok), 32'd1);
        chk("s2_rdA", inst_rdata, 32'h11111111);
        tick();
        rvalid = 0; settle();
        chk("s2_dokB", 32'(data_ok), 32'd1);
        chk("s2_rdB", inst_rdata, 32'h22222222);
        tick(); settle();
        chk("s2_dok_end", 32'(data_ok), 32'd0);
        tick();

        // outstanding limit: third request waits for the first data_ok
        n_acc = 0; arready = 1; req = 1;
        for (int i = 0; i < 8; i++) begin
            addr = 32'h1c001000 + 32'(n_acc * 4);
            settle();
            if (addr_ok) n_acc++;
            tick();
        end
        chk("s3_two_acc", 32'(n_acc), 32'd2);
        rvalid = 1; rdata = 32'haaaa0001; settle();
        chk("s3_block_a", 32'(addr_ok), 32'd0);
        tick();
        rvalid = 0; settle();
        chk("s3_block_b", 32'(addr_ok), 32'd0);
        chk("s3_dok1", 32'(data_ok), 32'd1);
        chk("s3_rd1", inst_rdata, 32'haaaa0001);
        tick(); settle();
        chk("s3_acc3", 32'(addr_ok), 32'd1);
        tick();
        req = 0; settle();
        chk("s3_araddr3", araddr, 32'h1c001008);
        tick();
        n_dok = 0; rvalid = 1;
        for (int i = 0; i < 6; i++) begin
            rdata = 32'hbbbb0000 + 32'(i);
            rvalid = (i < 2);
            settle();
            if (data_ok) n_dok++;
            tick();
        end
        chk("s3_drain", 32'(n_dok), 32'd2);

        // error response
        req = 1; addr = 32'h1c002000; settle();
        chk("s6_acc", 32'(addr_ok), 32'd1);
        tick();
        req = 0; tick();
        rvalid = 1; rresp = 2'b10; rdata = 32'h0badf00d; tick();
        rvalid = 0; rresp = 2'b00; settle();
        chk("s6_dok", 32'(data_ok), 32'd1);
        chk("s6_err", 32'(rd_err), 32'(EXP_ERR));
        for (int i = 0; i < 4; i++) tick();
        settle();
        chk("s6_sticky", 32'(rd_err), 32'(EXP_ERR));
        tick();

        // flushed request still completes exactly once
        req = 1; addr = 32'h1c003000; settle();
        chk("s4_acc", 32'(addr_ok), 32'd1);
        tick();
        req = 0; tick();
        n_dok = 0;
        for (int i = 0; i < 6; i++) begin
            rvalid = (i == 0); rdata = 32'h33333333;
            settle();
            if (data_ok) n_dok++;
            tick();
        end
        chk("s4_one_dok", 32'(n_dok), 32'd1);

        // two accepts prove the count drained, leaving one AR pending
        req = 1; addr = 32'h1c004000; settle();
        chk("s7_accA", 32'(addr_ok), 32'd1);
        tick();
        settle(); tick();
        addr = 32'h1c004004; settle();
        chk("s7_accB", 32'(addr_ok), 32'd1);
        tick();
        req = 0; arready = 0; settle();
        chk("s7_arv_hi", 32'(arvalid), 32'd1);

        // reset with two outstanding and arvalid high
        reset = 1; tick(); settle();
        chk("s7_arvalid", 32'(arvalid), 32'd0);
        chk("s7_araddr", araddr, 32'd0);
        chk("s7_arsize", 32'(arsize), 32'd0);
        chk("s7_rready", 32'(rready), 32'd0);
        chk("s7_data_ok", 32'(data_ok), 32'd0);
        chk("s7_rdata", inst_rdata, 32'd0);
        chk("s7_rd_err", 32'(rd_err), 32'd0);
        tick();
        reset = 0; tick();
        req = 1; arready = 1; n_acc = 0;
        for (int i = 0; i < 4; i++) begin
            settle();
            if (addr_ok) n_acc++;
            tick();
        end
        req = 0;
        chk("s7_post_acc", 32'(n_acc), 32'd2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
